// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver for com_RxD with a small receive FIFO.
// Each frame is sampled at mid-bit from a fixed clock divisor. Good bytes
// are queued and handed to the consumer over a valid/ready handshake.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// after the data bits. This also adds the sticky parity_err_o output.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       com_RxD_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       err_clr_i,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       rx_busy_o
);

    localparam int                DEPTH     = 1 << FIFO_AW;
    localparam int                CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0]  DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      baudCnt_q, baudCnt_d;
    logic [2:0]         bitIdx_q, bitIdx_d;
    logic [7:0]         shift_q, shift_d;
    logic               pushValid_q, pushValid_d;
    logic [1:0]         sync_q;
    logic               rxs;
    logic               frameErrEvt;
    logic               frameErr_q;
    logic               overrun_q;
    logic               overrunEvt;
    logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
    logic [FIFO_AW:0]   count_q;
    logic [7:0]         mem_q [DEPTH];
    logic               doPush, doPop, fifoFull;
`ifdef UART_RX_PARITY_EN
    logic               parityBad_q, parityBad_d;
    logic               parityErrEvt;
    logic               parityErr_q;
`endif

    assign rxs = sync_q[1];

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], com_RxD_i};
    end

    // Receive FSM state, baud timer, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            pushValid_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            pushValid_q <= pushValid_d;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= parityBad_d;
`endif
        end
    end

    // Next-state logic. Each timed state counts down to zero and then samples rxs.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        pushValid_d = 1'b0;
        frameErrEvt = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBad_d  = parityBad_q;
        parityErrEvt = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d   = START;
                    baudCnt_d = HALF_LOAD;
`ifdef UART_RX_PARITY_EN
                    parityBad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (baudCnt_q != '0) begin
                    baudCnt_d = baudCnt_q - CW'(1);
                end else if (!rxs) begin
                    state_d   = DATA;
                    baudCnt_d = FULL_LOAD;
                    bitIdx_d  = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (baudCnt_q != '0) begin
                    baudCnt_d = baudCnt_q - CW'(1);
                end else begin
                    shift_d[bitIdx_q] = rxs;
                    baudCnt_d         = FULL_LOAD;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baudCnt_q != '0) begin
                    baudCnt_d = baudCnt_q - CW'(1);
                end else begin
                    parityBad_d  = (rxs != ^shift_q);
                    parityErrEvt = (rxs != ^shift_q);
                    baudCnt_d    = FULL_LOAD;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (baudCnt_q != '0) begin
                    baudCnt_d = baudCnt_q - CW'(1);
                end else if (rxs) begin
`ifdef UART_RX_PARITY_EN
                    pushValid_d = !parityBad_q;
`else
                    pushValid_d = 1'b1;
`endif
                    state_d = IDLE;
                end else begin
                    frameErrEvt = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_valid_o = (count_q != '0);
    assign fifoFull   = (count_q == DEPTH_CNT);
    assign doPop      = rx_valid_o && rx_ready_i;
    assign doPush     = pushValid_q && (!fifoFull || doPop);
    assign overrunEvt = pushValid_q && fifoFull && !doPop;
    assign rx_data_o  = rx_valid_o ? mem_q[rdPtr_q] : 8'h00;
    assign rx_busy_o  = (state_q != IDLE);

    // FIFO storage. It needs no reset because rx_data_o is gated by rx_valid_o.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= shift_q;
    end

    // FIFO pointers and fill level. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + FIFO_AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + FIFO_AW'(1);
            if (doPush && !doPop)      count_q <= count_q + (FIFO_AW + 1)'(1);
            else if (!doPush && doPop) count_q <= count_q - (FIFO_AW + 1)'(1);
        end
    end

    // Sticky error flags. A new event in the same cycle as err_clr_i wins over the clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
        end else begin
            frameErr_q <= (frameErr_q & ~err_clr_i) | frameErrEvt;
            overrun_q  <= (overrun_q & ~err_clr_i) | overrunEvt;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= (parityErr_q & ~err_clr_i) | parityErrEvt;
`endif
        end
    end

    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parityErr_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the system's com_RxD line: 8N1, LSB first, idle high.
- Frames are sampled at mid-bit from a fixed clock divisor and written into a small FIFO.
- Received bytes are presented to the CPU-side bus bridge through a valid/ready handshake.
- It is the receive-side counterpart of the system's com_TxD transmitter and runs in the main system clock domain.

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200). Must be ≥ 4.
- FIFO_AW, 2, FIFO address width. Depth is 2^FIFO_AW entries.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- com_RxD  in  1  asynchronous serial input, idle high.
- rx_data  out  8  byte at the FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head byte; a pop occurs on a clock edge where rx_valid && rx_ready.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a completed byte was dropped because the FIFO was full.
- err_clr  in  1  single-cycle pulse; clears frame_err and overrun.
- rx_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE, FIFO emptied, bit counter and baud counter = 0, synchronizer flops = 1. All outputs read 0; rx_data reads 8'h00.
- com_RxD passes through a 2-flop synchronizer; "rxs" below denotes the synchronized value. There is no further filtering.
- IDLE: when rxs==0, go to START and load the baud counter.
- START: wait CLKS_PER_BIT/2 clocks (integer divide), then sample rxs.
  - rxs==0 → go to DATA with bit index 0.
  - rxs==1 → glitch; return to IDLE with no flag set.
- DATA: wait CLKS_PER_BIT clocks, sample rxs into shift register bit[index] (LSB first). After bit 7, go to STOP.
- STOP: wait CLKS_PER_BIT clocks, sample rxs.
  - rxs==1 → push the byte to the FIFO, go to IDLE.
  - rxs==0 → set frame_err, discard the byte, go to BREAK.
- BREAK: stay until rxs==1, then go to IDLE. A held-low line is never accepted as a new start bit.
- Latency: rx_valid rises on the clk edge after the edge on which the stop bit is sampled. rx_data is valid while rx_valid is high and holds stable until popped.
- FIFO: one write pointer and one read pointer of FIFO_AW bits, plus a count of FIFO_AW+1 bits. Pointers wrap modulo depth.
  - Push when full with no pop in the same cycle → byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle when full → both occur; count unchanged; no overrun.
  - Push and pop in the same cycle at any other level → count unchanged.
  - Pop when empty → ignored.
- err_clr takes priority over a same-cycle flag set only for the older events. If a new error occurs in the same cycle as err_clr, the flag ends set.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. A line still low after reset goes IDLE→START and is resampled, which is normal start detection.
- rx_busy = (FSM != IDLE).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the 8 data bits, and the FSM passes through a PARITY state of CLKS_PER_BIT clocks before STOP.
  - A mismatch sets a sticky parity_err output, cleared by err_clr, and the byte is discarded.
  - The parity_err port exists only when the macro is defined.
- Undefined: frames are plain 8N1, the PARITY state is absent, and there is no parity_err port.

Test Plan (CLKS_PER_BIT=16, FIFO_AW=2):
- Basic receive: send 8'hA5 as 8N1 with rx_ready=1 → exactly one rx_valid pulse with rx_data=8'hA5; frame_err=0; rx_busy returns to 0.
- Glitch rejection: pulse com_RxD low for 4 clocks → FSM returns to IDLE, no rx_valid, no flags.
- Framing error: send 8'h3C with stop bit low, then hold the line low for 40 clocks, then send 8'h81 → frame_err=1; 3C not delivered; FSM stays in BREAK until the line goes high; 81 received; err_clr clears frame_err.
- Overrun: rx_ready=0, send 8'h01..8'h05 → rx_valid=1, overrun=1 after byte 5; popping yields 01,02,03,04 and then rx_valid=0.
- Simultaneous push/pop at full: fill with 4 bytes, assert rx_ready for 1 cycle on the stop-sample edge of a 5th byte 8'hEE → overrun=0; FIFO holds 4 entries ending in EE.
- Reset mid-frame: drop rst_n for 1 cycle during DATA bit 3 of 8'hFF → no byte delivered, all outputs 0; the next frame 8'h5A is received correctly.
